dm_write_buffer: RTL

Posted-store buffer between the datapath's memory stage and the data memory. Stores from the CPU enqueue into a small FIFO and drain to the data memory's single write port one per cycle, decoupling store issue from memory write timing. Loads probe the buffer in the same cycle; the youngest pending store to the same word forwards its data. The store PC travels with each entry so the memory's write trace keeps the originating instruction address.

---
 rtl/dm_write_buffer_pkg.sv | 15 +
 rtl/dm_write_buffer_if.sv | 24 ++
 rtl/wb_fifo_ctrl.sv | 61 ++++++
 rtl/dm_write_buffer.sv | 91 +++++++++
 4 files changed

// File: rtl/dm_write_buffer_pkg.sv
// Shared types and constants for the posted-store write buffer.
// Entry layout, default depth and word-index slice bounds.
package dm_write_buffer_pkg;

  localparam int WB_DEPTH = 4;
  localparam int WORD_LSB = 2;
  localparam int WORD_MSB = 13;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } wb_entry_t;

endpackage

// File: rtl/dm_write_buffer_if.sv
// CPU-side store request and load probe bundle for the write buffer.
// master = memory stage, slave = dm_write_buffer.
interface dm_write_buffer_if;

  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [31:0] st_pc;
  logic        st_ready;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;

  modport master (
    output st_valid, st_addr, st_data, st_pc, ld_addr,
    input  st_ready, ld_hit, ld_data
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_pc, ld_addr,
    output st_ready, ld_hit, ld_data
  );

endinterface

// File: rtl/wb_fifo_ctrl.sv
// Head/tail/count bookkeeping for the write buffer FIFO.
// Ports: push/pop requests in, accepted push/pop, pointers, count, full/empty out.
module wb_fifo_ctrl #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_req,
  input  logic          pop_req,
  output logic          push,
  output logic          pop,
  output logic [PW-1:0] head,
  output logic [PW-1:0] tail,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Full is judged on the registered count only, so a push
  // is refused when full even if the head drains this cycle.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = push_req && !full;
  assign pop   = pop_req && !empty;

  assign head  = head_q;
  assign tail  = tail_q;
  assign count = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dm_write_buffer.sv
// Posted-store buffer between memory stage and data memory write port.
// Ports: clk/reset, cpu (store+load probe), dm_stall, dm_* write port, empty, count.
module dm_write_buffer #(
  parameter int DEPTH = dm_write_buffer_pkg::WB_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  dm_write_buffer_if.slave         cpu,
  input  logic                     dm_stall,
  output logic                     dm_we,
  output logic [31:0]              dm_addr,
  output logic [31:0]              dm_wd,
  output logic [31:0]              dm_pc,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  import dm_write_buffer_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [PW-1:0] head, tail, slot;
  logic [CW-1:0] cnt;
  logic          full, push, pop;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic          unused_ld;

  wb_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .push_req (cpu.st_valid),
    .pop_req  (!dm_stall),
    .push     (push),
    .pop      (pop),
    .head     (head),
    .tail     (tail),
    .count    (cnt),
    .full     (full),
    .empty    (empty)
  );

  assign cpu.st_ready = !full;
  assign count        = cnt;

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[tail] = '{addr: cpu.st_addr,
                      data: cpu.st_data,
                      pc:   cpu.st_pc};
    end
  end

  // Storage carries no reset; stale slots are masked by count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dm_we   = pop;
  assign dm_addr = mem_q[head].addr;
  assign dm_wd   = mem_q[head].data;
  assign dm_pc   = mem_q[head].pc;

  // Walk from oldest to youngest; later matches override,
  // so the entry nearest the tail wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PW'(i);
      if (CW'(i) < cnt &&
          mem_q[slot].addr[WORD_MSB:WORD_LSB] ==
          cpu.ld_addr[WORD_MSB:WORD_LSB]) begin
        fwd_hit  = 1'b1;
        fwd_data = mem_q[slot].data;
      end
    end
  end

  assign cpu.ld_hit  = fwd_hit;
  assign cpu.ld_data = fwd_data;

  assign unused_ld = ^{cpu.ld_addr[31:WORD_MSB+1],
                       cpu.ld_addr[WORD_LSB-1:0]};

endmodule
